// File: rtl/lvds_frame_sequencer.sv
// lvds_frame_sequencer
//   Generates the pixel-rate timing for a 7:1 LVDS panel from the bit clock:
//   a free-running 0..6 bit-slot counter, H/V raster counters and
//   DE/HSYNC/VSYNC. Active pixels are prefetched from the frame buffer
//   through a small credit-limited FIFO and presented as RGB888, held
//   stable for each 7-slot pixel frame, to the slot-mux/serializer stage.
//
// Ports
//   clk_in       bit clock (7x pixel rate), the only clock
//   rst_n        synchronous active-low reset
//   enable       1 = start/keep scanning, 0 = stop at end of current frame
//   fb_req       frame-buffer read request (held with fb_addr until accepted)
//   fb_addr      linear pixel index of the request
//   fb_ready     request accepted when fb_req & fb_ready
//   fb_rvalid    read data valid, in-order responses
//   fb_rdata     {red, green, blue}
//   red/green/blue  pixel to serializer, 0 outside the active region
//   hsync/vsync/de  raster controls for the current pixel
//   bit_slot     serializer slot index 0..6
//   pix_strobe   1 while bit_slot == 0
//   frame_start  1-cycle pulse on the first slot of pixel (0,0)
//   underflow    sticky: an active pixel found the FIFO empty
//   busy         sequencer is not idle
module lvds_frame_sequencer #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_TOTAL    = 1440,
    parameter int V_ACTIVE   = 800,
    parameter int V_TOTAL    = 823,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 8,
    parameter int PREFILL    = 4
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              enable,
    output logic              fb_req,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic              fb_ready,
    input  logic              fb_rvalid,
    input  logic [23:0]       fb_rdata,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [2:0]        bit_slot,
    output logic              pix_strobe,
    output logic              frame_start,
    output logic              underflow,
    output logic              busy
);

    localparam int H_W   = $clog2(H_TOTAL + 1);
    localparam int V_W   = $clog2(V_TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT     = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT     = V_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  PREFILL_C = CNT_W'(PREFILL);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_RUN     = 2'd2,
        S_STOP    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [H_W-1:0]   h_cnt, h_next, disp_h;
    logic [V_W-1:0]   v_cnt, v_next, disp_v;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [23:0]      mem [FIFO_DEPTH];
    logic [CNT_W:0]   credit_used;

    logic boundary;
    logic last_pixel;
    logic load;
    logic disp_active;
    logic fetch_ok;
    logic accept;
    logic rsp;
    logic push;
    logic pop;
    logic starve;

    // Pixel frames end on slot 6; everything pixel-rate happens on that edge.
    assign boundary    = (bit_slot == 3'd6);
    assign last_pixel  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign credit_used = {1'b0, count} + {1'b0, outstanding};

    // Once STOP has seen fb_addr wrap to 0 the rest of the frame is already
    // fetched, so further requests would only fetch the next frame.
    assign fetch_ok = (state == S_PREFILL) || (state == S_RUN) ||
                      ((state == S_STOP) && (fb_addr != '0));
    assign fb_req   = fetch_ok && (credit_used < {1'b0, DEPTH_C});
    assign accept   = fb_req && fb_ready;

    // Responses with nothing outstanding are stray and ignored; responses
    // arriving while idle still retire credit but are discarded.
    assign rsp  = fb_rvalid && (outstanding != '0);
    assign push = rsp && (state != S_IDLE);

    assign disp_active = load && (disp_h < H_ACT) && (disp_v < V_ACT);
    assign pop         = disp_active && (count != '0);
    assign starve      = disp_active && (count == '0);

    assign busy       = (state != S_IDLE);
    assign pix_strobe = rst_n && (bit_slot == 3'd0);

    // Raster position following the current one.
    always_comb begin
        h_next = h_cnt + H_W'(1);
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the decision whether a new pixel is loaded this edge.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        disp_h     = h_next;
        disp_v     = v_next;
        case (state)
            S_IDLE: begin
                if (enable && (outstanding == '0)) begin
                    state_next = S_PREFILL;
                end
            end
            S_PREFILL: begin
                disp_h = '0;
                disp_v = '0;
                if (boundary && (count >= PREFILL_C)) begin
                    state_next = S_RUN;
                    load       = 1'b1;
                end
            end
            S_RUN, S_STOP: begin
                state_next = enable ? S_RUN : S_STOP;
                if (boundary) begin
                    if (!enable && last_pixel) begin
                        state_next = S_IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control: slot counter, credit, FIFO occupancy, fetch address.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            bit_slot    <= 3'd0;
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fb_addr     <= '0;
            underflow   <= 1'b0;
        end else begin
            bit_slot <= boundary ? 3'd0 : bit_slot + 3'd1;

            case ({accept, rsp})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (state == S_IDLE) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end

            if (state == S_IDLE) begin
                fb_addr <= '0;
            end else if (accept) begin
                fb_addr <= (fb_addr == ADDR_LAST) ? '0 : fb_addr + ADDR_W'(1);
            end

            if ((state == S_IDLE) && (state_next == S_PREFILL)) begin
                underflow <= 1'b0;
            end else if (starve) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= fb_rdata;
        end
    end

    // Pixel stage: raster position and outputs change only at slot 6 -> 0.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            red         <= 8'd0;
            green       <= 8'd0;
            blue        <= 8'd0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (boundary) begin
                if (load) begin
                    h_cnt       <= disp_h;
                    v_cnt       <= disp_v;
                    hsync       <= (disp_h < H_ACT);
                    vsync       <= (disp_v < V_ACT);
                    de          <= disp_active;
                    frame_start <= (disp_h == '0) && (disp_v == '0) &&
                                   (state_next == S_RUN);
                    // A starved active pixel shows black; its data is not
                    // skipped, so later pixels simply shift.
                    {red, green, blue} <= pop ? mem[rd_ptr] : 24'd0;
                end else begin
                    if (state_next == S_IDLE) begin
                        h_cnt <= '0;
                        v_cnt <= '0;
                    end
                    hsync <= 1'b0;
                    vsync <= 1'b0;
                    de    <= 1'b0;
                    {red, green, blue} <= 24'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lvds_frame_sequencer.sv
module tb_lvds_frame_sequencer;

    localparam int HA    = 4;
    localparam int HT    = 6;
    localparam int VA    = 2;
    localparam int VT    = 3;
    localparam int NPIX  = HA * VA;
    localparam int FR    = HT * VT;
    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fb_req;
    logic [19:0] fb_addr;
    logic        fb_ready;
    logic        fb_rvalid;
    logic [23:0] fb_rdata;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, de;
    logic [2:0]  bit_slot;
    logic        pix_strobe, frame_start, underflow, busy;

    always #5 clk_in = ~clk_in;

    lvds_frame_sequencer #(
        .H_ACTIVE  (HA),
        .H_TOTAL   (HT),
        .V_ACTIVE  (VA),
        .V_TOTAL   (VT),
        .ADDR_W    (20),
        .FIFO_DEPTH(DEPTH),
        .PREFILL   (4)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .enable     (enable),
        .fb_req     (fb_req),
        .fb_addr    (fb_addr),
        .fb_ready   (fb_ready),
        .fb_rvalid  (fb_rvalid),
        .fb_rdata   (fb_rdata),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .bit_slot   (bit_slot),
        .pix_strobe (pix_strobe),
        .frame_start(frame_start),
        .underflow  (underflow),
        .busy       (busy)
    );

    typedef struct {
        int due;
        int addr;
    } rsp_t;

    int total = 0;
    int bad   = 0;

    // Stimulus knobs
    bit rst_i, en_i, spur_en;
    int ready_pct, lat_min, lat_max;

    // Frame-buffer contents for one frame (address -> pixel)
    logic [23:0] memv [NPIX];
    rsp_t        pend[$];
    int          ncyc, last_due;

    // Reference model: pixel-index view of the raster
    int          sl;          // slot value in the current cycle
    int          out_m;       // requests accepted but not yet answered
    int          avail;       // pixels buffered and not yet shown
    int          popk;        // buffered pixels shown since the fetch restarted
    int          next_addr;   // address the next accepted request must carry
    int          p;           // pixels shown since scanning began
    bit          m_busy, m_scan, last_en;
    bit          prev_stall;
    int          prev_addr;
    logic [23:0] exp_rgb;
    bit          exp_hs, exp_vs, exp_de, exp_fs, exp_uf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sl = 0; out_m = 0; avail = 0; popk = 0; next_addr = 0; p = 0;
        m_busy = 0; m_scan = 0; last_en = 0; prev_stall = 0; prev_addr = 0;
        exp_rgb = 24'd0; exp_hs = 0; exp_vs = 0; exp_de = 0; exp_fs = 0; exp_uf = 0;
        pend.delete();
    endtask

    // Present pixel number p; consumes a buffered pixel if it is active.
    task automatic show();
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        exp_hs  = (h < HA);
        exp_vs  = (v < VA);
        exp_de  = exp_hs && exp_vs;
        exp_fs  = ((p % FR) == 0);
        exp_rgb = 24'd0;
        if (exp_de) begin
            if (avail > 0) begin
                exp_rgb = memv[popk % NPIX];
                popk++;
                avail--;
            end else begin
                exp_uf = 1;
            end
        end
    endtask

    task automatic step();
        bit real_rv, spur, pre_req, acc, rsp, push, bnd;
        int pre_addr, lat, due, newout;
        @(negedge clk_in);
        rst_n   = rst_i;
        enable  = en_i;
        fb_ready = ($urandom_range(99, 0) < ready_pct);
        real_rv = rst_i && (pend.size() > 0) && (pend[0].due <= ncyc + 1);
        spur    = rst_i && !real_rv && (pend.size() == 0) && spur_en &&
                  ($urandom_range(9, 0) == 0);
        fb_rvalid = real_rv || spur;
        fb_rdata  = real_rv ? memv[pend[0].addr] : 24'($urandom);
        #1;
        pre_req  = fb_req;
        pre_addr = int'(fb_addr);
        if (rst_i) begin
            check("credit", 32'(out_m + avail <= DEPTH), 32'd1);
            if (m_scan && !last_en)
                check("stop_no_wrap_req", 32'(pre_req && (next_addr == 0)), 32'd0);
            if (prev_stall && m_busy && !(m_scan && !last_en)) begin
                check("stall_req", 32'(pre_req), 32'd1);
                check("stall_addr", 32'(pre_addr), 32'(prev_addr));
            end
        end
        @(posedge clk_in);
        ncyc++;
        if (!rst_i) begin
            model_reset();
        end else begin
            acc    = pre_req && fb_ready;
            rsp    = fb_rvalid && (out_m > 0);
            push   = rsp && m_busy;
            bnd    = (sl == 6);
            newout = out_m + int'(acc) - int'(rsp);
            if (acc) begin
                check("fetch_addr", 32'(pre_addr), 32'(next_addr));
                lat = int'($urandom_range(lat_max, lat_min));
                due = ncyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{due: due, addr: next_addr});
                next_addr = (next_addr + 1) % NPIX;
            end
            if (real_rv) void'(pend.pop_front());
            prev_stall = pre_req && !fb_ready;
            prev_addr  = pre_addr;
            exp_fs = 0;
            if (!m_busy) begin
                if (en_i && (out_m == 0)) begin
                    m_busy = 1; avail = 0; popk = 0; next_addr = 0; exp_uf = 0;
                end
            end else if (!m_scan) begin
                if (bnd && (avail >= 4)) begin
                    m_scan = 1;
                    p = 0;
                    show();
                end
            end else if (bnd) begin
                if (!en_i && ((p % FR) == FR - 1)) begin
                    m_busy = 0; m_scan = 0; avail = 0;
                    exp_rgb = 24'd0; exp_hs = 0; exp_vs = 0; exp_de = 0;
                end else begin
                    p++;
                    show();
                end
            end
            if (push && m_busy) avail++;
            out_m   = newout;
            sl      = bnd ? 0 : sl + 1;
            last_en = en_i;
        end
        #1;
        check("bit_slot", 32'(bit_slot), 32'(sl));
        check("pix_strobe", 32'(pix_strobe), 32'((sl == 0) && rst_i));
        check("busy", 32'(busy), 32'(m_busy));
        check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
        check("hsync", 32'(hsync), 32'(exp_hs));
        check("vsync", 32'(vsync), 32'(exp_vs));
        check("de", 32'(de), 32'(exp_de));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("underflow", 32'(underflow), 32'(exp_uf));
        if (!m_busy) check("req_idle", 32'(fb_req), 32'd0);
    endtask

    task automatic run_to_pos(input int pos, input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (m_scan && (sl == 0) && ((p % FR) == pos)) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic run_to_idle(input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!m_busy) begin
                to = 0;
                break;
            end
        end
    endtask

    initial begin
        bit to;
        for (int i = 0; i < NPIX; i++) memv[i] = 24'($urandom);
        ncyc = 0; last_due = 0;
        model_reset();
        rst_i = 0; en_i = 0; spur_en = 0;
        ready_pct = 100; lat_min = 2; lat_max = 2;
        rst_n = 1'b0; enable = 1'b0; fb_ready = 1'b0; fb_rvalid = 1'b0; fb_rdata = 24'd0;

        // Power-on reset
        repeat (3) step();
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_req", 32'(fb_req), 32'd0);

        // Steady scanning, always-ready memory, fixed 2-cycle latency
        rst_i = 1; en_i = 1;
        repeat (420) step();

        // Reset pulse in the middle of a frame
        check("midrun_busy_before", 32'(busy), 32'd1);
        rst_i = 0;
        step();
        check("midrst_slot", 32'(bit_slot), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req", 32'(fb_req), 32'd0);
        check("midrst_rgb", 32'({red, green, blue}), 32'd0);
        check("midrst_sync", 32'({hsync, vsync, de, frame_start, underflow}), 32'd0);

        // Random back-pressure, latency and stray responses
        rst_i = 1; ready_pct = 75; lat_min = 1; lat_max = 4; spur_en = 1;
        repeat (800) step();

        // Starve the fetch path for several lines
        run_to_pos(0, 300, to);
        check("align_starve_timeout", 32'(to), 32'd0);
        ready_pct = 0;
        repeat (200) step();
        ready_pct = 100;
        repeat (30) step();
        check("starve_underflow", 32'(underflow), 32'd1);
        repeat (100) step();

        // Drop enable on pixel h=2,v=0: frame completes, then idle
        run_to_pos(2, 400, to);
        check("align_stop_timeout", 32'(to), 32'd0);
        en_i = 0;
        run_to_idle(400, to);
        check("stop_idle_timeout", 32'(to), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        repeat (20) step();

        // Restart clears the sticky underflow
        en_i = 1; ready_pct = 80;
        to = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_busy) begin
                to = 0;
                break;
            end
        end
        check("restart_timeout", 32'(to), 32'd0);
        check("restart_uf_clear", 32'(underflow), 32'd0);
        repeat (600) step();

        // Leave and re-enter STOP before the frame ends
        run_to_pos(5, 400, to);
        check("align_resume_timeout", 32'(to), 32'd0);
        en_i = 0;
        repeat (30) step();
        en_i = 1;
        repeat (300) step();
        check("resume_busy", 32'(busy), 32'd1);

        // Final stop
        en_i = 0;
        run_to_idle(500, to);
        check("final_idle_timeout", 32'(to), 32'd0);
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
